// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer between the IF stage and the instruction memory.
// Keeps up to DEPTH fetches in flight or buffered, returns instructions in
// order, and discards responses that belong to fetches cancelled by a flush.
module inst_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  output logic          c_addr_ok,
  output logic          c_data_ok,
  output logic [DW-1:0] c_rdata,
  input  logic          c_data_ready,
  output logic          m_req,
  output logic [AW-1:0] m_addr,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = DEPTH[PW+1:0];

  logic [PW:0]   inflight;    // accepted, not yet returned (incl. cancelled)
  logic [PW:0]   cancel_cnt;  // responses still to be discarded
  logic [PW:0]   count;       // valid FIFO entries
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic [PW+1:0] occupancy;
  logic          admit;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;

  // Admission and handshake decode; every accepted fetch already owns a FIFO slot.
  always_comb begin
    occupancy = {1'b0, inflight} + {1'b0, count};
    admit     = (occupancy < DEPTH_W) & ~flush & ~reset;
    m_req     = c_req & admit;
    m_addr    = c_addr;
    c_addr_ok = m_req & m_addr_ok;
    accept    = c_addr_ok;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp      = m_data_ok & (inflight != '0);
    push      = resp & (cancel_cnt == '0) & ~flush;
    c_data_ok = (count != '0);
    pop       = c_data_ok & c_data_ready & ~flush;
    c_rdata   = c_data_ok ? mem[rd_ptr] : '0;
  end

  // Outstanding/cancel counters and FIFO pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= '0;
      cancel_cnt <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      case ({accept, resp})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (flush) begin
        // Everything still outstanding after this cycle's return is stale.
        cancel_cnt <= inflight - {{PW{1'b0}}, resp};
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (resp && cancel_cnt != '0) cancel_cnt <= cancel_cnt - 1'b1;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Instruction storage written on every accepted response.
  // NOTE: the data array has no reset; occupancy is tracked by count alone and
  // c_rdata is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= m_rdata;
  end

  // Memory must never return data when nothing is outstanding.
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
    !(m_data_ok && inflight == '0));

endmodule
